// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Shares the single-ported Memory_System between instruction fetch
// (read-only) and load/store (read/write). It grants at most one access per
// cycle, drives the memory bus from the winner, and steers the read data
// returned one cycle later back to the requester that owns it.
//
// Ports:
//   clk, reset                 system clock (rising edge), async active-high reset
//   If_Req_i / If_Addr_i       fetch request and address (held until granted)
//   If_Gnt_o                   fetch accepted this cycle (combinational)
//   If_Valid_o / If_Data_o     fetched word, one cycle after If_Gnt_o
//   Ls_Req_i / Ls_We_i         load/store request, 1 = store
//   Ls_Addr_i / Ls_Wdata_i     load/store address and store data
//   Ls_Gnt_o                   load/store accepted this cycle (combinational)
//   Ls_Valid_o / Ls_Rdata_o    load data / store ack, one cycle after Ls_Gnt_o
//   Address_o, Write_Enable_o,
//   Write_Data_o               memory bus to Memory_System
//   Read_Data_i                synchronous read data from Memory_System
//
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   undefined : load/store has priority; fetch wins once load/store has been
//               granted STARVE_LIMIT times in a row while fetch waited.
//   defined   : alternate between requesters when both request.
//
// Return-path owner states:
//   state    | meaning
//   OWN_IDLE | nothing granted last cycle, Read_Data_i is ignored
//   OWN_IF   | Read_Data_i belongs to fetch
//   OWN_LS   | Read_Data_i belongs to load/store (load data or store ack)

module mem_access_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  If_Req_i,
  input  logic [ADDR_WIDTH-1:0] If_Addr_i,
  output logic                  If_Gnt_o,
  output logic                  If_Valid_o,
  output logic [DATA_WIDTH-1:0] If_Data_o,
  input  logic                  Ls_Req_i,
  input  logic                  Ls_We_i,
  input  logic [ADDR_WIDTH-1:0] Ls_Addr_i,
  input  logic [DATA_WIDTH-1:0] Ls_Wdata_i,
  output logic                  Ls_Gnt_o,
  output logic                  Ls_Valid_o,
  output logic [DATA_WIDTH-1:0] Ls_Rdata_o,
  output logic [ADDR_WIDTH-1:0] Address_o,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Read_Data_i
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  owner_t                owner_q, owner_d;
  logic                  if_gnt, ls_gnt;
  logic [ADDR_WIDTH-1:0] addr_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = fetch won the most recent grant; reset value favours load/store first.
  logic last_if_q;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if (If_Req_i && Ls_Req_i) begin
        if_gnt = ~last_if_q;
        ls_gnt = last_if_q;
      end else begin
        if_gnt = If_Req_i;
        ls_gnt = Ls_Req_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_if_q <= 1'b1;
    end else if (if_gnt) begin
      last_if_q <= 1'b1;
    end else if (ls_gnt) begin
      last_if_q <= 1'b0;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       fetch_escape;

  assign fetch_escape = (starve_cnt == LIMIT);

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if (If_Req_i && (!Ls_Req_i || fetch_escape)) begin
        if_gnt = 1'b1;
      end else if (Ls_Req_i) begin
        ls_gnt = 1'b1;
      end
    end
  end

  // Counts load/store grants taken while fetch was waiting; saturates so the
  // escape condition stays asserted until fetch actually gets in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!If_Req_i || if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (ls_gnt && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  assign If_Gnt_o = if_gnt;
  assign Ls_Gnt_o = ls_gnt;

  // Bus drive: winner's address, otherwise hold the last granted one so the
  // memory address lines do not toggle on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else if (if_gnt) begin
      addr_q <= If_Addr_i;
    end else if (ls_gnt) begin
      addr_q <= Ls_Addr_i;
    end
  end

  assign Address_o      = if_gnt ? If_Addr_i : (ls_gnt ? Ls_Addr_i : addr_q);
  assign Write_Enable_o = ls_gnt & Ls_We_i;
  assign Write_Data_o   = reset ? '0 : Ls_Wdata_i;

  // Return-path owner FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt) begin
      owner_d = OWN_LS;
    end
  end

  assign If_Valid_o = (owner_q == OWN_IF);
  assign Ls_Valid_o = (owner_q == OWN_LS);
  assign If_Data_o  = If_Valid_o ? Read_Data_i : '0;
  assign Ls_Rdata_o = Ls_Valid_o ? Read_Data_i : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: a small synchronous-read memory, directed
// scenarios and a randomized request phase, all checked against a
// transaction-level model of who should win and what data should return.

module tb_mem_access_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        If_Req_i = 1'b0;
  logic [31:0] If_Addr_i = '0;
  logic        If_Gnt_o, If_Valid_o;
  logic [31:0] If_Data_o;
  logic        Ls_Req_i = 1'b0;
  logic        Ls_We_i = 1'b0;
  logic [31:0] Ls_Addr_i = '0;
  logic [31:0] Ls_Wdata_i = '0;
  logic        Ls_Gnt_o, Ls_Valid_o;
  logic [31:0] Ls_Rdata_o;
  logic [31:0] Address_o;
  logic        Write_Enable_o;
  logic [31:0] Write_Data_o;
  logic [31:0] Read_Data_i;

  mem_access_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .If_Req_i(If_Req_i), .If_Addr_i(If_Addr_i), .If_Gnt_o(If_Gnt_o),
    .If_Valid_o(If_Valid_o), .If_Data_o(If_Data_o),
    .Ls_Req_i(Ls_Req_i), .Ls_We_i(Ls_We_i), .Ls_Addr_i(Ls_Addr_i),
    .Ls_Wdata_i(Ls_Wdata_i), .Ls_Gnt_o(Ls_Gnt_o), .Ls_Valid_o(Ls_Valid_o),
    .Ls_Rdata_o(Ls_Rdata_o), .Address_o(Address_o),
    .Write_Enable_o(Write_Enable_o), .Write_Data_o(Write_Data_o),
    .Read_Data_i(Read_Data_i)
  );

  always #5 clk = ~clk;

  // Memory_System stand-in: 16 words indexed by address[5:2], read-first.
  logic [31:0] mem [16];
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    rd_q <= mem[Address_o[5:2]];
    if (Write_Enable_o) mem[Address_o[5:2]] <= Write_Data_o;
  end
  assign Read_Data_i = rd_q;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] shadow [16];
  int          streak;        // consecutive LS wins while fetch waited
  bit          last_was_if;   // round-robin memory
  logic [31:0] hold_addr;
  bit          pend_if, pend_ls;
  logic [31:0] pend_data;
  bit          g_if, g_ls;    // model grant of the latest step
  bit          obs_if_gnt;    // DUT fetch grant of the latest step

  task automatic model_reset();
    streak = 0; last_was_if = 1'b1; hold_addr = '0;
    pend_if = 1'b0; pend_ls = 1'b0; pend_data = '0;
  endtask

  // One clock cycle. Entered and left at 1 time unit after a rising edge.
  task automatic step(input bit ir, input logic [31:0] ia, input bit lr,
                      input bit lw, input logic [31:0] la, input logic [31:0] ld);
    logic [31:0] ea;
    If_Req_i = ir; If_Addr_i = ia;
    Ls_Req_i = lr; Ls_We_i = lw; Ls_Addr_i = la; Ls_Wdata_i = ld;
    #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ir && lr) g_if = !last_was_if;
    else          g_if = ir;
`else
    g_if = ir && (!lr || streak == LIM);
`endif
    g_ls = lr && !g_if;
    ea = g_if ? ia : (g_ls ? la : hold_addr);
    obs_if_gnt = If_Gnt_o;
    chk("if_gnt", {31'd0, If_Gnt_o}, {31'd0, g_if});
    chk("ls_gnt", {31'd0, Ls_Gnt_o}, {31'd0, g_ls});
    chk("addr", Address_o, ea);
    chk("we", {31'd0, Write_Enable_o}, {31'd0, g_ls && lw});
    if (g_ls && lw) chk("wdata", Write_Data_o, ld);
    chk("if_valid", {31'd0, If_Valid_o}, {31'd0, pend_if});
    chk("ls_valid", {31'd0, Ls_Valid_o}, {31'd0, pend_ls});
    chk("if_data", If_Data_o, pend_if ? pend_data : 32'd0);
    chk("ls_rdata", Ls_Rdata_o, pend_ls ? pend_data : 32'd0);
    // advance model to the next cycle
    pend_if = g_if; pend_ls = g_ls;
    pend_data = shadow[ea[5:2]];
    if (g_ls && lw) shadow[ea[5:2]] = ld;
    if (g_if || g_ls) hold_addr = ea;
    if (!ir || g_if) streak = 0;
    else if (g_ls && streak < LIM) streak++;
    if (g_if) last_was_if = 1'b1;
    else if (g_ls) last_was_if = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Reset asserted mid-cycle with a load/store request present.
  task automatic do_reset();
    Ls_Req_i = 1'b1; Ls_We_i = 1'b1; Ls_Addr_i = 32'h1001_0008; Ls_Wdata_i = 32'hA5A5_A5A5;
    If_Req_i = 1'b1; If_Addr_i = 32'h0000_0010;
    #1 reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rst_if_gnt", {31'd0, If_Gnt_o}, 32'd0);
      chk("rst_ls_gnt", {31'd0, Ls_Gnt_o}, 32'd0);
      chk("rst_if_valid", {31'd0, If_Valid_o}, 32'd0);
      chk("rst_ls_valid", {31'd0, Ls_Valid_o}, 32'd0);
      chk("rst_if_data", If_Data_o, 32'd0);
      chk("rst_ls_rdata", Ls_Rdata_o, 32'd0);
      chk("rst_addr", Address_o, 32'd0);
      chk("rst_we", {31'd0, Write_Enable_o}, 32'd0);
      chk("rst_wdata", Write_Data_o, 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  bit          ip, lp, lwe;
  logic [31:0] ia_r, la_r, ld_r;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0100_0000 + i;
      shadow[i] = 32'h0100_0000 + i;
    end
    mem[1] = 32'h2009_0005;    shadow[1] = 32'h2009_0005;
    mem[2] = 32'h1111_1111;    shadow[2] = 32'h1111_1111;
    mem[3] = 32'h2222_2222;    shadow[3] = 32'h2222_2222;
    model_reset();
    g_if = 1'b0; g_ls = 1'b0; obs_if_gnt = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // first request after reset is granted in the same cycle
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
    chk("post_rst_gnt", {31'd0, Ls_Valid_o}, 32'd1);
    // in-flight read killed by reset
    step(1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'd0, 32'd0);
    do_reset();
    chk("inflight_drop", {31'd0, If_Valid_o}, 32'd0);

    // ROM fetch
    step(1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rom1_data", If_Data_o, 32'h2009_0005);
    chk("rom1_ls_zero", Ls_Rdata_o, 32'd0);
    idle();

    // store then load to the same address
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF);
    chk("st_ack", {31'd0, Ls_Valid_o}, 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h1001_0000, 32'd0);
    chk("ld_new", Ls_Rdata_o, 32'hDEAD_BEEF);
    idle();

    // fetch and load back-to-back with distinct words
    step(1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rt_if", If_Data_o, 32'h1111_1111);
    chk("rt_ls0", Ls_Rdata_o, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h1001_000C, 32'd0);
    chk("rt_ls", Ls_Rdata_o, 32'h2222_2222);
    chk("rt_if0", If_Data_o, 32'd0);
    idle();

    // both requesting continuously
`ifdef MEM_ARB_ROUND_ROBIN_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h1001_0000 + 32'((i % 4) * 4), 32'd0);
      chk("rr_pattern", {31'd0, obs_if_gnt}, {31'd0, (i % 2) == 1});
    end
`else
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 1'b0, 32'h1001_0000 + 32'((i % 4) * 4), 32'd0);
      chk("starve_pattern", {31'd0, obs_if_gnt}, {31'd0, (i % 5) == 4});
    end
`endif
    idle();

    // randomized traffic, requests held until granted
    ip = 1'b0; lp = 1'b0; lwe = 1'b0; ia_r = '0; la_r = '0; ld_r = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && ($urandom_range(0, 3) != 0)) begin
        ip = 1'b1; ia_r = 32'($urandom_range(0, 7) * 4);
      end
      if (!lp && ($urandom_range(0, 3) != 0)) begin
        lp = 1'b1; lwe = 1'($urandom_range(0, 1));
        la_r = 32'h1001_0000 + 32'($urandom_range(0, 3) * 4);
        ld_r = $urandom;
      end
      step(ip, ia_r, lp, lwe, la_r, ld_r);
      if (g_if) ip = 1'b0;
      if (g_ls) lp = 1'b0;
      if (c == 1500) begin
        do_reset();
        ip = 1'b0; lp = 1'b0;
      end
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
